// File: rtl/leaderboard_browser_pkg.sv
// Shared types and constants for the leaderboard browser.
package leaderboard_browser_pkg;

    localparam int TIME_W = 39;

    localparam logic [2:0] MODE_IDLE  = 3'd0;
    localparam logic [2:0] MODE_FAST1 = 3'd1;
    localparam logic [2:0] MODE_FAST2 = 3'd2;
    localparam logic [2:0] MODE_FAST3 = 3'd3;
    localparam logic [2:0] MODE_SLOW1 = 3'd4;
    localparam logic [2:0] MODE_SLOW2 = 3'd5;
    localparam logic [2:0] MODE_SLOW3 = 3'd6;

    localparam logic [1:0] SW_SLOW = 2'b01;
    localparam logic [1:0] SW_FAST = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BROWSE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_AUTO   = 2'd3
    } state_t;

    // Idle (code 0) steps forward into FAST1 and backward into SLOW3.
    function automatic logic [2:0] code_next(input logic [2:0] c);
        return (c == MODE_IDLE || c >= MODE_SLOW3) ? MODE_FAST1 : c + 3'd1;
    endfunction

    function automatic logic [2:0] code_prev(input logic [2:0] c);
        return (c <= MODE_FAST1) ? MODE_SLOW3 : c - 3'd1;
    endfunction

endpackage

// File: rtl/leaderboard_browser_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and pulses tick on the wrap cycle.
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/leaderboard_browser.sv
// Leaderboard display browser with new-record highlight.
// Optional auto-scroll mode: define LEADERBOARD_AUTO_SCROLL_EN.
//
// state  | meaning
// IDLE   | nothing shown, display_mode 0
// BROWSE | user stepping through the six entries
// HOLD   | new record shown and highlighted for HOLD_TICKS ticks
// AUTO   | entries advance every SCROLL_TICKS ticks (optional)
module leaderboard_browser
    import leaderboard_browser_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int HOLD_TICKS   = 3000,
    parameter int SCROLL_TICKS = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_exit,
    input  logic [1:0]        stopwatch_mode,
    input  logic              signal_sound_1,
    input  logic              signal_sound_2,
    input  logic              signal_sound_3,
    input  logic [TIME_W-1:0] fast_1,
    input  logic [TIME_W-1:0] fast_2,
    input  logic [TIME_W-1:0] fast_3,
    input  logic [TIME_W-1:0] slow_1,
    input  logic [TIME_W-1:0] slow_2,
    input  logic [TIME_W-1:0] slow_3,
    output logic [2:0]        display_mode,
    output logic [TIME_W-1:0] sel_time,
    output logic              sel_valid,
    output logic              highlight
);
    localparam int CNT_MAX = (HOLD_TICKS > SCROLL_TICKS) ? HOLD_TICKS : SCROLL_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);
`ifdef LEADERBOARD_AUTO_SCROLL_EN
    localparam logic [CNT_W-1:0] SCROLL_LOAD = CNT_W'(SCROLL_TICKS);
`endif

    state_t           state, state_nxt;
    logic [2:0]       code, code_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             auto_ret, auto_ret_nxt;
    logic [2:0]       sound_now, sound_prev, toggled;
    logic [1:0]       rec_k;
    logic [2:0]       rec_code;
    logic             rec_hit, one_btn, tick;
    logic [2:0]       step_code;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign sound_now = {signal_sound_3, signal_sound_2, signal_sound_1};
    assign toggled   = sound_now ^ sound_prev;
    assign rec_k     = toggled[0] ? 2'd1 : (toggled[1] ? 2'd2 : 2'd3);
    assign rec_code  = (stopwatch_mode == SW_FAST) ? {1'b0, rec_k} : 3'd3 + {1'b0, rec_k};
    assign rec_hit   = (|toggled) && (stopwatch_mode == SW_FAST || stopwatch_mode == SW_SLOW);
    assign one_btn   = btn_next ^ btn_prev;
    assign step_code = btn_next ? code_next(code) : code_prev(code);

    // Reset loads the current toggle levels so release never looks like a record.
    always_ff @(posedge clk) begin
        sound_prev <= sound_now;
        if (!rst_n) begin
            state    <= ST_IDLE;
            code     <= MODE_IDLE;
            cnt      <= '0;
            auto_ret <= 1'b0;
            sel_time <= '0;
        end else begin
            state    <= state_nxt;
            code     <= code_nxt;
            cnt      <= cnt_nxt;
            auto_ret <= auto_ret_nxt;
            case (code)
                MODE_FAST1: sel_time <= fast_1;
                MODE_FAST2: sel_time <= fast_2;
                MODE_FAST3: sel_time <= fast_3;
                MODE_SLOW1: sel_time <= slow_1;
                MODE_SLOW2: sel_time <= slow_2;
                MODE_SLOW3: sel_time <= slow_3;
                default:    sel_time <= '0;
            endcase
        end
    end

    // Priority: exit, then record event, then buttons, then tick expiry.
    always_comb begin
        state_nxt    = state;
        code_nxt     = code;
        cnt_nxt      = cnt;
        auto_ret_nxt = auto_ret;
        if (btn_exit) begin
            state_nxt    = ST_IDLE;
            code_nxt     = MODE_IDLE;
            cnt_nxt      = '0;
            auto_ret_nxt = 1'b0;
        end else if (rec_hit) begin
            state_nxt    = ST_HOLD;
            code_nxt     = rec_code;
            cnt_nxt      = HOLD_LOAD;
            auto_ret_nxt = (state == ST_AUTO) || (state == ST_HOLD && auto_ret);
        end else begin
            case (state)
                ST_IDLE, ST_BROWSE: begin
                    if (one_btn) begin
                        state_nxt = ST_BROWSE;
                        code_nxt  = step_code;
                    end
`ifdef LEADERBOARD_AUTO_SCROLL_EN
                    else if (btn_next && btn_prev) begin
                        state_nxt = ST_AUTO;
                        code_nxt  = (state == ST_IDLE) ? MODE_FAST1 : code;
                        cnt_nxt   = SCROLL_LOAD;
                    end
`endif
                end
                ST_HOLD: begin
                    if (one_btn) begin
                        state_nxt    = ST_BROWSE;
                        code_nxt     = step_code;
                        cnt_nxt      = '0;
                        auto_ret_nxt = 1'b0;
                    end else if (tick) begin
                        if (cnt <= CNT_W'(1)) begin
                            state_nxt    = ST_BROWSE;
                            cnt_nxt      = '0;
                            auto_ret_nxt = 1'b0;
`ifdef LEADERBOARD_AUTO_SCROLL_EN
                            if (auto_ret) begin
                                state_nxt = ST_AUTO;
                                cnt_nxt   = SCROLL_LOAD;
                            end
`endif
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end
                end
`ifdef LEADERBOARD_AUTO_SCROLL_EN
                ST_AUTO: begin
                    if (one_btn) begin
                        state_nxt = ST_BROWSE;
                        cnt_nxt   = '0;
                    end else if (tick) begin
                        if (cnt <= CNT_W'(1)) begin
                            code_nxt = code_next(code);
                            cnt_nxt  = SCROLL_LOAD;
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_nxt = ST_IDLE;
                    code_nxt  = MODE_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        display_mode = code;
        sel_valid    = (code != MODE_IDLE);
        highlight    = (state == ST_HOLD);
    end
endmodule

// File: tb/tb_leaderboard_browser.sv
// Directed bench for leaderboard_browser (TICK_DIV=4, HOLD_TICKS=3, SCROLL_TICKS=2).
module tb_leaderboard_browser;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_next, btn_prev, btn_exit;
    logic [1:0]  stopwatch_mode;
    logic        s1, s2, s3;
    logic [38:0] fast_1, fast_2, fast_3, slow_1, slow_2, slow_3;
    logic [2:0]  display_mode;
    logic [38:0] sel_time;
    logic        sel_valid, highlight;

    logic [38:0] ent [0:6];
    int          n_vec = 0;
    int          n_err = 0;
    int          tb_cyc = 0;
    int          w;

    leaderboard_browser #(.TICK_DIV(4), .HOLD_TICKS(3), .SCROLL_TICKS(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_next       (btn_next),
        .btn_prev       (btn_prev),
        .btn_exit       (btn_exit),
        .stopwatch_mode (stopwatch_mode),
        .signal_sound_1 (s1),
        .signal_sound_2 (s2),
        .signal_sound_3 (s3),
        .fast_1         (fast_1),
        .fast_2         (fast_2),
        .fast_3         (fast_3),
        .slow_1         (slow_1),
        .slow_2         (slow_2),
        .slow_3         (slow_3),
        .display_mode   (display_mode),
        .sel_time       (sel_time),
        .sel_valid      (sel_valid),
        .highlight      (highlight)
    );

    always #5 clk = ~clk;

    // Mirrors the free-running prescaler phase: edge n carries a tick when n%4==3.
    always @(posedge clk) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic align_tick();
        while ((tb_cyc % 4) != 3) step();
    endtask

    task automatic pulse(input logic nx, input logic pv, input logic ex);
        btn_next = nx; btn_prev = pv; btn_exit = ex;
        step();
        btn_next = 1'b0; btn_prev = 1'b0; btn_exit = 1'b0;
    endtask

    task automatic hold_width(output int width);
        width = 0;
        while (highlight && width < 40) begin
            width++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fast_1 = 39'h00_0000_1111; fast_2 = 39'h00_0000_2222; fast_3 = 39'h00_0000_3333;
        slow_1 = 39'h40_0000_4444; slow_2 = 39'h55_5555_5555; slow_3 = 39'h7F_FFFF_FFFF;
        ent[0] = '0;     ent[1] = fast_1; ent[2] = fast_2; ent[3] = fast_3;
        ent[4] = slow_1; ent[5] = slow_2; ent[6] = slow_3;
        btn_next = 0; btn_prev = 0; btn_exit = 0;
        stopwatch_mode = 2'b01;
        s1 = 1'b1; s2 = 1'b0; s3 = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_mode",   64'(display_mode), 64'd0);
        chk("rst_valid",  64'(sel_valid),    64'd0);
        chk("rst_hl",     64'(highlight),    64'd0);
        chk("rst_time",   64'(sel_time),     64'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("rel_no_hold", 64'(highlight),    64'd0);
        chk("rel_mode",    64'(display_mode), 64'd0);

        for (int i = 0; i < 7; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            chk($sformatf("next_%0d", i), 64'(display_mode), 64'((i % 6) + 1));
            step();
            chk($sformatf("time_%0d", i), 64'(sel_time), 64'(ent[(i % 6) + 1]));
        end
        pulse(1'b0, 1'b0, 1'b1);
        chk("exit_mode",  64'(display_mode), 64'd0);
        chk("exit_valid", 64'(sel_valid),    64'd0);
        step();
        chk("exit_time",  64'(sel_time),     64'd0);

        pulse(1'b0, 1'b1, 1'b0);
        chk("prev_idle", 64'(display_mode), 64'd6);
        pulse(1'b0, 1'b1, 1'b0);
        chk("prev_5",    64'(display_mode), 64'd5);
        pulse(1'b1, 1'b0, 1'b1);
        chk("exit_next_mode",  64'(display_mode), 64'd0);
        chk("exit_next_valid", 64'(sel_valid),    64'd0);

        // Slow board record on rank 2, timed so the event lands on a tick edge.
        stopwatch_mode = 2'b01;
        align_tick();
        s2 = 1'b1;
        step();
        chk("rec_slow_code", 64'(display_mode), 64'd5);
        chk("rec_slow_hl",   64'(highlight),    64'd1);
        hold_width(w);
        chk("hold_width", 64'(w), 64'd12);
        chk("hold_end_code", 64'(display_mode), 64'd5);
        chk("hold_end_valid", 64'(sel_valid),   64'd1);

        // Fast board, ranks 1 and 3 together: rank 1 wins; rank 2 retargets mid-hold.
        stopwatch_mode = 2'b10;
        s1 = 1'b0; s3 = 1'b1;
        step();
        chk("multi_code", 64'(display_mode), 64'd1);
        chk("multi_hl",   64'(highlight),    64'd1);
        repeat (2) step();
        align_tick();
        s2 = 1'b0;
        step();
        chk("retarget_code", 64'(display_mode), 64'd2);
        hold_width(w);
        chk("restart_width", 64'(w), 64'd12);
        stopwatch_mode = 2'b00;
        s3 = 1'b0;
        step();
        chk("mode00_code", 64'(display_mode), 64'd2);
        chk("mode00_hl",   64'(highlight),    64'd0);

        stopwatch_mode = 2'b10;
        s1 = 1'b1;
        pulse(1'b0, 1'b0, 1'b1);
        chk("exit_prio_code", 64'(display_mode), 64'd0);
        chk("exit_prio_hl",   64'(highlight),    64'd0);

        s1 = 1'b0;
        step();
        chk("hold_btn_pre", 64'(display_mode), 64'd1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("hold_btn_code", 64'(display_mode), 64'd2);
        chk("hold_btn_hl",   64'(highlight),    64'd0);

        stopwatch_mode = 2'b01;
        s3 = 1'b1;
        step();
        chk("pre_rst_code", 64'(display_mode), 64'd6);
        step();
        rst_n = 1'b0;
        step();
        chk("midhold_rst_mode", 64'(display_mode), 64'd0);
        chk("midhold_rst_hl",   64'(highlight),    64'd0);
        rst_n = 1'b1;
        step();
        chk("midhold_rst_time", 64'(sel_time),     64'd0);
        chk("midhold_rst_hl2",  64'(highlight),    64'd0);

        align_tick();
        pulse(1'b1, 1'b1, 1'b0);
`ifdef LEADERBOARD_AUTO_SCROLL_EN
        chk("auto_entry", 64'(display_mode), 64'd1);
        repeat (7) step();
        chk("auto_before_adv", 64'(display_mode), 64'd1);
        for (int j = 2; j <= 7; j++) begin
            step();
            chk($sformatf("auto_adv_%0d", j), 64'(display_mode), 64'(((j - 1) % 6) + 1));
            if (j < 7) repeat (7) step();
        end
        pulse(1'b1, 1'b0, 1'b0);
        repeat (16) step();
        chk("auto_exit_browse", 64'(display_mode), 64'd1);
`else
        chk("both_idle", 64'(display_mode), 64'd0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        chk("both_browse", 64'(display_mode), 64'd1);
        repeat (16) step();
        chk("both_no_auto", 64'(display_mode), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/leaderboard_browser.md
LEADERBOARD_BROWSER -- requirements
Module: leaderboard_browser

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000; clk cycles per tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter HOLD_TICKS, default 3000; ticks a new-record highlight is held.
REQ-003 SHALL have parameter SCROLL_TICKS, default 2000; ticks per entry in auto-scroll.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports btn_next, btn_prev, btn_exit  in  1 each  single-cycle debounced pulses.
REQ-007 SHALL have port stopwatch_mode  in  2  01 slow board, 10 fast board, other none.
REQ-008 SHALL have ports signal_sound_1/2/3  in  1 each  toggle-per-new-record, ranks 1/2/3.
REQ-009 SHALL have ports fast_1..3, slow_1..3  in  39 each  stored leaderboard entries.
REQ-010 SHALL have port display_mode  out  3  0 idle, 1-3 fast rank 1-3, 4-6 slow rank 1-3.
REQ-011 SHALL have port sel_time  out  39  entry selected by display_mode, registered.
REQ-012 SHALL have port sel_valid  out  1  high when display_mode nonzero.
REQ-013 SHALL have port highlight  out  1  high while in HOLD state.

Function
REQ-014 SHALL implement states IDLE, BROWSE, HOLD, and AUTO (AUTO only per REQ-028).
REQ-015 IDLE: display_mode 0; btn_next -> BROWSE, code 1; btn_prev -> BROWSE, code 6.
REQ-016 BROWSE: btn_next increments code, 6 wraps to 1; btn_prev decrements, 1 wraps to 6.
REQ-017 btn_next and btn_prev in the same cycle SHALL be ignored.
REQ-018 btn_exit SHALL force IDLE, code 0, from any state; exit has priority over every other event.
REQ-019 Record event: any signal_sound_k differs from its registered previous value; the previous-value register SHALL update every cycle.
REQ-020 On a record event with stopwatch_mode 10, code SHALL be k; with 01, code SHALL be 3+k; other modes SHALL ignore the event (no state change).
REQ-021 Multiple toggles in one cycle: lowest k SHALL win.
REQ-022 Record event from any state except exit-cycle SHALL enter HOLD, load tick counter with HOLD_TICKS, highlight 1 next cycle.
REQ-023 A record event during HOLD SHALL retarget code and restart the hold count.
REQ-024 HOLD expiry SHALL return to BROWSE with code unchanged; btn_next/prev during HOLD SHALL go to BROWSE and step code per REQ-016.
REQ-025 Tick prescaler SHALL count 0..TICK_DIV-1, free-running, wrapping; hold/scroll counters decrement only on wrap.
REQ-026 sel_time SHALL equal the entry for display_mode one cycle after display_mode changes; 0 when code 0.

Reset
REQ-027 On rst_n low at a rising edge: state IDLE, display_mode 0, sel_time 0, sel_valid 0, highlight 0, prescaler and counters 0, previous-toggle registers loaded from current signal_sound_1..3 (no spurious event after reset); reset mid-HOLD/AUTO SHALL abandon it.

Configuration
REQ-028 Macro LEADERBOARD_AUTO_SCROLL_EN defined: btn_next and btn_prev in the same cycle from IDLE or BROWSE SHALL enter AUTO. AUTO SHALL advance the code per REQ-016 every SCROLL_TICKS ticks. Any single button in AUTO SHALL return to BROWSE. Record events in AUTO SHALL behave per REQ-022, and HOLD expiry SHALL then return to AUTO. Macro undefined: no AUTO state, and REQ-017 applies.

Structure
REQ-029 Shared package SHALL hold TIME_W=39, the display_mode code constants (MODE_IDLE, MODE_FAST1..MODE_SLOW3), the stopwatch_mode constants, and the state enum.
REQ-030 Tick prescaler SHALL be sub-module tick_gen (params DIV; ports clk, rst_n, tick).

Verification
REQ-031 Reset, then btn_next x7 -> display_mode 1,2,3,4,5,6,1; sel_time tracks fast_1..slow_3 one cycle later.
REQ-032 IDLE, btn_prev -> code 6; btn_prev -> 5; btn_exit together with btn_next -> code 0, sel_valid 0.
REQ-033 stopwatch_mode 01, toggle signal_sound_2 -> code 5, highlight 1 for HOLD_TICKS ticks (use TICK_DIV=4, HOLD_TICKS=3: 12 clocks ±1), then BROWSE code 5.
REQ-034 stopwatch_mode 10, toggle sound_1 and sound_3 in the same cycle -> code 1. Toggle sound_2 during HOLD -> code 2, hold restarts. stopwatch_mode 00 toggle -> no change.
REQ-035 signal_sound_1 held 1 through reset release -> no HOLD entry. Assert reset mid-HOLD -> IDLE, highlight 0.
REQ-036 With LEADERBOARD_AUTO_SCROLL_EN and SCROLL_TICKS=2, TICK_DIV=4: next+prev together -> AUTO, code advances every 8 clocks, 6 wraps to 1. Without the macro, the same stimulus gives no change.
